// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch sequencing FSM driving a 4-digit BCD counter chain
module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic [15:0] cnt_value,
  output logic        count_en,
  output logic        counter_clr,
  output logic [15:0] disp_value,
  output logic        running,
  output logic        lap_active,
  output logic        full
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE,
    S_FULL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prev_ss;
  logic             prev_lr;
  logic [PRE_W-1:0] prescaler;
  logic [15:0]      lap_q;

  logic ss_ev;
  logic lr_ev;
  logic live;
  logic tick;
  logic at_max;

  // Start/stop always beats lap/reset when both rise together.
  assign ss_ev  = btn_ss & ~prev_ss;
  assign lr_ev  = btn_lr & ~prev_lr & ~ss_ev;
  assign live   = (state == S_RUN) | (state == S_LAP);
  assign tick   = live & (prescaler == PRE_MAX);
  assign at_max = (cnt_value == 16'h9999);

  // The chain saturates at 9999: the tick that would overflow it is swallowed.
  assign count_en    = tick & ~at_max;
  assign counter_clr = lr_ev & ((state == S_IDLE) | (state == S_PAUSE) | (state == S_FULL));
  assign disp_value  = (state == S_LAP) ? lap_q : cnt_value;

  // Next-state selection; button events take priority over saturation.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (ss_ev) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (ss_ev)               state_nxt = S_PAUSE;
        else if (lr_ev)          state_nxt = S_LAP;
        else if (tick && at_max) state_nxt = S_FULL;
      end
      S_LAP: begin
        if (ss_ev)               state_nxt = S_PAUSE;
        else if (lr_ev)          state_nxt = S_RUN;
        else if (tick && at_max) state_nxt = S_FULL;
      end
      S_PAUSE: begin
        if (ss_ev)      state_nxt = S_RUN;
        else if (lr_ev) state_nxt = S_IDLE;
      end
      S_FULL: begin
        if (lr_ev) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, button history, prescaler, lap latch and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      prev_ss    <= 1'b1;
      prev_lr    <= 1'b1;
      prescaler  <= '0;
      lap_q      <= 16'h0000;
      running    <= 1'b0;
      lap_active <= 1'b0;
      full       <= 1'b0;
    end else begin
      state   <= state_nxt;
      prev_ss <= btn_ss;
      prev_lr <= btn_lr;

      if (state_nxt == S_IDLE) begin
        prescaler <= '0;
      end else if (live) begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
      end

      // Capture the value before any increment happening on this same edge.
      if ((state == S_RUN) && lr_ev) begin
        lap_q <= cnt_value;
      end

      running    <= (state_nxt == S_RUN) | (state_nxt == S_LAP);
      lap_active <= (state_nxt == S_LAP);
      full       <= (state_nxt == S_FULL);
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM that sequences a 4-digit BCD counter chain of cascaded unit-digit cells.
- Generates the chain's count-enable tick from a prescaler, and issues synchronous clear pulses.
- Handles start/stop and lap/reset buttons, and freezes the displayed value during lap.
- Sits between debounced push-buttons, the digit chain (chain's c_in is driven by count_en; chain's q outputs feed back as cnt_value) and the 7-seg display driver.

Parameters:
TICK_DIV, 500000, clk cycles per count tick (>=2); 0.01 s at 50 MHz
PRE_W, $clog2(TICK_DIV), prescaler width (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
btn_ss  input  1  start/stop button level (debounced, synchronous)
btn_lr  input  1  lap/reset button level (debounced, synchronous)
cnt_value  input  16  current chain value, 4 BCD digits, [15:12] most significant
count_en  output  1  tick to chain c_in, one cycle per increment
counter_clr  output  1  synchronous clear to chain, one-cycle pulse
disp_value  output  16  value for display (BCD)
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP
full  output  1  high in FULL

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - state=IDLE, prescaler=0, lap latch=16'h0000.
  - Button history regs=1, so a button held through reset causes no event.
  - All outputs 0, except disp_value=cnt_value.
- Edge detect:
  - ss_ev = btn_ss & ~prev_ss; lr_ev = btn_lr & ~prev_lr.
  - prev regs update every cycle, so events fire one clk after the level rises.
  - Held buttons produce exactly one event.
- Simultaneous events: ss_ev wins; lr_ev in the same cycle is discarded.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN/LAP and wraps to 0 after TICK_DIV-1.
  - Holds its value in PAUSE and is cleared to 0 on entering IDLE.
  - tick = running & (prescaler==TICK_DIV-1).
- count_en (combinational): tick & (cnt_value!=16'h9999). The chain increments at the same edge.
- States / transitions (evaluated each edge):
  - IDLE:
    - ss_ev -> RUN, prescaler starts from 0.
    - lr_ev -> stay IDLE, counter_clr=1 this cycle.
  - RUN:
    - ss_ev -> PAUSE.
    - lr_ev -> LAP; lap latch <= cnt_value (the pre-increment value if count_en is also high this cycle).
    - tick with cnt_value==16'h9999 -> FULL; no count_en.
  - LAP:
    - Counting continues; disp_value=lap latch.
    - lr_ev -> RUN (display live again).
    - ss_ev -> PAUSE (display live again).
    - Saturation -> FULL, same rule as RUN.
  - PAUSE:
    - ss_ev -> RUN, prescaler resumes from its held value.
    - lr_ev -> IDLE, counter_clr=1 this cycle, prescaler <= 0.
  - FULL:
    - count_en never asserted; ss_ev ignored.
    - lr_ev -> IDLE with counter_clr=1.
- An event and a tick in the same cycle: the tick's count_en is still issued (it depends on the current state); the transition applies at that edge.
- counter_clr (combinational): lr_ev & state in {IDLE, PAUSE, FULL} & ~ss_ev.
- disp_value: lap latch in LAP, otherwise cnt_value.
- Reset mid-operation: reset overrides everything and returns to IDLE on the same edge. The chain is reset by the same reset line.
- cnt_value is compared only for ==16'h9999; non-BCD inputs need no special handling.

Test Plan:
- TICK_DIV=4; reset 2 cycles; pulse btn_ss -> running=1 next cycle; count_en every 4th cycle. After 40 cycles, the chain (bench model) reads 16'h0010.
- RUN at 16'h0123, press btn_lr -> lap_active=1 and disp_value stays 16'h0123 while cnt_value advances. Press btn_lr again -> disp_value tracks cnt_value, lap_active=0.
- RUN, press btn_ss at prescaler=2 -> PAUSE, count_en stays 0 for 20 cycles. Press btn_ss -> first count_en exactly 1 cycle after re-entering RUN (prescaler resumed at 3).
- PAUSE, press btn_lr -> counter_clr high exactly one cycle, state IDLE, disp_value=16'h0000. btn_lr pressed in IDLE also gives one clr pulse.
- Force cnt_value=16'h9999 in RUN -> at the tick: no count_en, full=1, running=0. btn_ss ignored; btn_lr -> counter_clr pulse, IDLE.
- btn_ss and btn_lr rising on the same cycle in RUN -> PAUSE only, no lap capture. Button held across reset release -> no event. reset asserted in LAP -> IDLE, all outputs 0 next cycle.
